nasti_stream_arbiter: RTL
=========================

NASTI_STREAM_ARBITER -- requirements
Module: nasti_stream_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 2, giving the number of source stream channels (range 2..16).
REQ-002 SHALL have parameters ID_WIDTH 1, DEST_WIDTH 1, USER_WIDTH 1 and DATA_WIDTH 64, giving the channel field widths.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port src, an N_SRC-element array of nasti_stream_channel.slave: the requesting streams.
REQ-006 SHALL have port dest, a nasti_stream_channel.master: the shared output, normally driving a stream buffer.
REQ-007 SHALL have port grant, output, N_SRC bits: one-hot current owner; all zero when idle.

Function
REQ-008 SHALL implement a two-state FSM, IDLE and LOCKED.
REQ-009 In IDLE, dest.t_valid SHALL be 0, every src[i].t_ready SHALL be 0, and grant SHALL be 0.
REQ-010 In IDLE with at least one src[i].t_valid high, the block SHALL pick a winner round-robin, searching from index (last+1) mod N_SRC upward with wrap, register it in grant, and enter LOCKED next cycle.
REQ-011 In LOCKED, all dest t_* payload fields and t_valid SHALL combinationally equal those of src[owner], and src[owner].t_ready SHALL equal dest.t_ready.
REQ-012 In LOCKED, t_ready to every non-owner source SHALL be 0.
REQ-013 Packet end is a beat with src[owner].t_valid, dest.t_ready and t_last all high; on that beat the FSM SHALL return to IDLE and set last to owner.
REQ-014 SHALL never switch owner mid-packet; a single-beat packet (t_last on its first beat) releases after that beat.
REQ-015 SHALL add exactly one idle arbitration cycle between consecutive packets, so peak throughput is L/(L+1) for L-beat packets.
REQ-016 Owner t_valid dropping mid-packet SHALL NOT release the lock.
REQ-017 A new request arriving during LOCKED SHALL wait for the next IDLE cycle; a sole requester SHALL be re-granted.
REQ-018 The last pointer SHALL be $clog2(N_SRC) bits wide and wrap modulo N_SRC, also for non-power-of-2 N_SRC.

Reset
REQ-019 While areset is high, the FSM SHALL be forced to IDLE, last SHALL be set to N_SRC-1 (so src[0] has first priority), grant to 0, dest.t_valid to 0 and all src t_ready to 0.
REQ-020 Reset asserted mid-packet SHALL drop the packet with no further beats issued; the stream buffer downstream is reset by its own reset.

Configuration
REQ-021 With macro NASTI_STREAM_ARB_STATS_EN defined, the block SHALL add output pkt_cnt, N_SRC x 16 bits, one wrapping counter per source incremented on each completed packet (REQ-013) and cleared by reset.
REQ-022 Without NASTI_STREAM_ARB_STATS_EN, the pkt_cnt port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-023 Package nasti_stream_arb_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and a round-robin next-index function.
REQ-024 Sub-module nasti_stream_rr_pick SHALL be used: combinational, with inputs req[N_SRC] and last, and output a one-hot winner.
REQ-025 Payload muxing SHALL be flattened per field from the interface array with generate loops.

Verification
REQ-026 Reset release with src0 and src1 both sending 3-beat packets, dest.t_ready=1 -> grant sequence 01,10,01; one idle cycle between packets; 6 beats in 8 cycles after the first grant.
REQ-027 src1 alone with a 1-beat packet, repeated -> grant 10 every other cycle; dest.t_last=1 on each beat.
REQ-028 src0 packet of 4 beats, src0 t_valid low in cycle 2, dest.t_ready toggling -> no owner change, beats intact and in order, src1.t_ready held 0 throughout.
REQ-029 N_SRC=3, all sources requesting continuously -> grants 001,010,100,001, with correct wrap.
REQ-030 areset pulsed during beat 2 of a 4-beat packet -> next cycle IDLE, grant 0, dest.t_valid 0; then src0 is first winner.
REQ-031 With NASTI_STREAM_ARB_STATS_EN, 5 packets from src1 -> pkt_cnt[1]=5 and pkt_cnt[0]=0; 65536 packets -> pkt_cnt wraps to 0.

Source files
------------

// File: rtl/nasti_stream_arb_pkg.sv
// Shared types for the NASTI stream arbiter: FSM state encoding and the
// round-robin index step used by the winner search.
package nasti_stream_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Next index after idx, wrapping at n (works for non-power-of-2 n).
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/nasti_stream_channel_if.sv
// NASTI (AXI4-Stream) channel: master drives valid/payload, slave drives ready.
interface nasti_stream_channel #(
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1,
   parameter int DATA_WIDTH = 64
);
   logic                    t_valid;
   logic                    t_ready;
   logic [DATA_WIDTH-1:0]   t_data;
   logic [DATA_WIDTH/8-1:0] t_strb;
   logic [DATA_WIDTH/8-1:0] t_keep;
   logic                    t_last;
   logic [ID_WIDTH-1:0]     t_id;
   logic [DEST_WIDTH-1:0]   t_dest;
   logic [USER_WIDTH-1:0]   t_user;

   modport master (output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
                   input  t_ready);
   modport slave  (input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
                   output t_ready);
endinterface

// File: rtl/nasti_stream_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1, with wrap.
module nasti_stream_rr_pick
   import nasti_stream_arb_pkg::*;
#(
   parameter  int N_SRC = 2,
   localparam int LW    = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [LW-1:0]    last,
   output logic [N_SRC-1:0] winner
);

   always_comb begin
      logic [LW-1:0] idx;
      logic          found;
      winner = '0;
      found  = 1'b0;
      idx    = LW'(rr_next(32'(last), N_SRC));
      for (int k = 0; k < N_SRC; k++) begin
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
         idx = LW'(rr_next(32'(idx), N_SRC));
      end
   end

endmodule

// File: rtl/nasti_stream_arbiter.sv
// Packet-locked round-robin arbiter merging N_SRC NASTI streams onto one output.
// Optional per-source packet counters are enabled by NASTI_STREAM_ARB_STATS_EN.
module nasti_stream_arbiter
   import nasti_stream_arb_pkg::*;
#(
   parameter int N_SRC      = 2,
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1,
   parameter int DATA_WIDTH = 64
) (
   input  logic                aclk,
   input  logic                areset,
   nasti_stream_channel.slave  src [N_SRC],
   nasti_stream_channel.master dest,
   output logic [N_SRC-1:0]    grant
`ifdef NASTI_STREAM_ARB_STATS_EN
   ,
   output logic [N_SRC-1:0][15:0] pkt_cnt
`endif
);

   localparam int LW = $clog2(N_SRC);
   localparam int SW = DATA_WIDTH / 8;

   logic [N_SRC-1:0]                 s_vld, s_last, s_rdy;
   logic [N_SRC-1:0][DATA_WIDTH-1:0] s_data;
   logic [N_SRC-1:0][SW-1:0]         s_strb, s_keep;
   logic [N_SRC-1:0][ID_WIDTH-1:0]   s_id;
   logic [N_SRC-1:0][DEST_WIDTH-1:0] s_dest;
   logic [N_SRC-1:0][USER_WIDTH-1:0] s_user;

   for (genvar i = 0; i < N_SRC; i++) begin : g_flat
      assign s_vld[i]       = src[i].t_valid;
      assign s_last[i]      = src[i].t_last;
      assign s_data[i]      = src[i].t_data;
      assign s_strb[i]      = src[i].t_strb;
      assign s_keep[i]      = src[i].t_keep;
      assign s_id[i]        = src[i].t_id;
      assign s_dest[i]      = src[i].t_dest;
      assign s_user[i]      = src[i].t_user;
      assign src[i].t_ready = s_rdy[i];
   end

   arb_state_e       state_q, state_d;
   logic [LW-1:0]    last_q, last_d;
   logic [LW-1:0]    owner_q, owner_d;
   logic [N_SRC-1:0] grant_q, grant_d;
   logic [N_SRC-1:0] pick;
   logic [LW-1:0]    pick_idx;
   logic             pkt_end;
   logic             dest_vld;

   nasti_stream_rr_pick #(.N_SRC(N_SRC)) u_pick (
      .req    (s_vld),
      .last   (last_q),
      .winner (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_SRC; i++)
         if (pick[i]) pick_idx = LW'(i);
   end

   // AND-OR mux on the one-hot grant; grant_q is zero outside LOCKED.
   logic                  m_vld, m_last;
   logic [DATA_WIDTH-1:0] m_data;
   logic [SW-1:0]         m_strb, m_keep;
   logic [ID_WIDTH-1:0]   m_id;
   logic [DEST_WIDTH-1:0] m_dest;
   logic [USER_WIDTH-1:0] m_user;

   always_comb begin
      m_vld  = 1'b0;
      m_last = 1'b0;
      m_data = '0;
      m_strb = '0;
      m_keep = '0;
      m_id   = '0;
      m_dest = '0;
      m_user = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) begin
            m_vld  |= s_vld[i];
            m_last |= s_last[i];
            m_data |= s_data[i];
            m_strb |= s_strb[i];
            m_keep |= s_keep[i];
            m_id   |= s_id[i];
            m_dest |= s_dest[i];
            m_user |= s_user[i];
         end
      end
   end

   assign pkt_end = (state_q == LOCKED) && m_vld && dest.t_ready && m_last;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         last_q  <= LW'(N_SRC - 1);
         owner_q <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (|s_vld) begin
               state_d = LOCKED;
               grant_d = pick;
               owner_d = pick_idx;
            end
         end
         LOCKED: begin
            // Only a completed last beat releases; a valid gap keeps the lock.
            if (pkt_end) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are also gated by areset so nothing leaks out during the reset cycle.
   always_comb begin
      dest_vld = 1'b0;
      s_rdy    = '0;
      if (state_q == LOCKED && !areset) begin
         dest_vld = m_vld;
         s_rdy    = grant_q & {N_SRC{dest.t_ready}};
      end
   end

   assign dest.t_valid = dest_vld;
   assign dest.t_data  = m_data;
   assign dest.t_strb  = m_strb;
   assign dest.t_keep  = m_keep;
   assign dest.t_last  = m_last;
   assign dest.t_id    = m_id;
   assign dest.t_dest  = m_dest;
   assign dest.t_user  = m_user;
   assign grant        = areset ? '0 : grant_q;

`ifdef NASTI_STREAM_ARB_STATS_EN
   logic [N_SRC-1:0][15:0] cnt_q;

   always_ff @(posedge aclk) begin
      if (areset)       cnt_q          <= '0;
      else if (pkt_end) cnt_q[owner_q] <= cnt_q[owner_q] + 16'd1;
   end

   assign pkt_cnt = cnt_q;
`endif

endmodule
